// File: rtl/gl6_video_pkg.sv
// gl6_video_pkg: shared types for the gl6 video stream blocks
package gl6_video_pkg;
   typedef enum logic {IDLE, GRANT} arb_state_t;
   typedef logic ch_id_t;
   localparam int NUM_CH = 2;
endpackage

// File: rtl/gl6_line_counter.sv
// gl6_line_counter: counts end-of-line handshakes within a frame, flags the final line
module gl6_line_counter #(
   parameter int LINES = 480
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic [$clog2(LINES+1)-1:0] cnt,
   output logic last_hit
);
   localparam int LC_W = $clog2(LINES + 1);
   assign last_hit = cnt == LC_W'(LINES - 1);
   always_ff @(posedge clk)
      if (rst || clr) cnt <= '0;
      else if (en) cnt <= last_hit ? '0 : cnt + LC_W'(1);
endmodule

// File: rtl/gl6_frame_arbiter.sv
// gl6_frame_arbiter: frame-granular round-robin share of one downscaler input between two sources
module gl6_frame_arbiter
   import gl6_video_pkg::*;
#(
   parameter int D_WIDTH = 8,
   parameter int LINES   = 480
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [D_WIDTH-1:0] ch0_data,
   input  logic               ch0_valid,
   input  logic               ch0_tlast,
   input  logic               ch0_tuser,
   output logic               ch0_ready,
   input  logic [D_WIDTH-1:0] ch1_data,
   input  logic               ch1_valid,
   input  logic               ch1_tlast,
   input  logic               ch1_tuser,
   output logic               ch1_ready,
   output logic [D_WIDTH-1:0] down_data,
   output logic               down_valid,
   output logic               down_tlast,
   output logic               down_tuser,
   input  logic               down_ready,
   output logic               gnt_active,
   output logic               gnt_id,
   output logic               frame_done,
   output logic               frame_err,
   output logic [NUM_CH-1:0]  drop
);
   localparam int LC_W = $clog2(LINES + 1);
   arb_state_t state;
   ch_id_t last_gnt, pick;
   logic started, grant, own_valid, own_tuser, own_tlast, abort, hs, own_rdy;
   logic req0, req1, new_grant, last_hit, frame_end;
   logic [LC_W-1:0] line_cnt;
   assign gnt_active = state == GRANT;
   always_comb begin
      grant      = state == GRANT;
      own_valid  = gnt_id ? ch1_valid : ch0_valid;
      own_tuser  = gnt_id ? ch1_tuser : ch0_tuser;
      own_tlast  = gnt_id ? ch1_tlast : ch0_tlast;
      // a second SOF once the frame is under way is held back for re-arbitration
      abort      = grant & (started | line_cnt != '0) & own_valid & own_tuser;
      down_valid = grant & own_valid & ~abort;
      down_data  = gnt_id ? ch1_data : ch0_data;
      down_tlast = own_tlast;
      down_tuser = own_tuser;
      hs         = down_valid & down_ready;
      own_rdy    = grant & down_ready & ~abort;
      ch0_ready  = grant ? own_rdy & ~gnt_id : ch0_valid & ~ch0_tuser;
      ch1_ready  = grant ? own_rdy & gnt_id : ch1_valid & ~ch1_tuser;
      req0       = ~grant & ch0_valid & ch0_tuser;
      req1       = ~grant & ch1_valid & ch1_tuser;
      pick       = req1 & (~req0 | last_gnt == 1'b0);
      new_grant  = req0 | req1;
      frame_end  = hs & own_tlast & last_hit;
   end
   gl6_line_counter #(.LINES(LINES)) u_line_cnt (
      .clk     (clk),
      .rst     (rst),
      .en      (hs & own_tlast),
      .clr     (new_grant | abort),
      .cnt     (line_cnt),
      .last_hit(last_hit)
   );
   always_ff @(posedge clk)
      if (rst) begin
         state      <= IDLE;
         gnt_id     <= 1'b0;
         last_gnt   <= 1'b1;
         started    <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         drop       <= '0;
      end else begin
         frame_done <= frame_end;
         frame_err  <= abort;
         drop       <= grant ? '0 : {ch1_valid & ~ch1_tuser, ch0_valid & ~ch0_tuser};
         if (new_grant) begin
            state    <= GRANT;
            gnt_id   <= pick;
            last_gnt <= pick;
            started  <= 1'b0;
         end else if (abort || frame_end) state <= IDLE;
         else if (hs) started <= 1'b1;
      end
endmodule

// File: tb/tb_gl6_frame_arbiter.sv
// tb_gl6_frame_arbiter: randomized scoreboard bench with per-source ordering and frame accounting
module tb_gl6_frame_arbiter;
   localparam int LINES = 4;
   typedef struct packed {logic [7:0] d; logic l; logic u;} beat_t;
   logic clk = 0, rst = 1;
   logic [1:0][7:0] c_data;
   logic [1:0] c_valid, c_last, c_user, c_ready;
   logic [7:0] down_data;
   logic down_valid, down_tlast, down_tuser, down_ready;
   logic gnt_active, gnt_id, frame_done, frame_err;
   logic [1:0] drop;
   beat_t expq [2][$];
   logic [6:0] seq [2];
   int order [$];
   int cnt_l [2];
   int drop_cnt [2];
   int checks = 0, errors = 0, done_cnt = 0, err_cnt = 0;
   bit exp_done = 0, rr = 0;

   gl6_frame_arbiter #(.D_WIDTH(8), .LINES(LINES)) dut (
      .clk(clk), .rst(rst),
      .ch0_data(c_data[0]), .ch0_valid(c_valid[0]), .ch0_tlast(c_last[0]),
      .ch0_tuser(c_user[0]), .ch0_ready(c_ready[0]),
      .ch1_data(c_data[1]), .ch1_valid(c_valid[1]), .ch1_tlast(c_last[1]),
      .ch1_tuser(c_user[1]), .ch1_ready(c_ready[1]),
      .down_data(down_data), .down_valid(down_valid), .down_tlast(down_tlast),
      .down_tuser(down_tuser), .down_ready(down_ready),
      .gnt_active(gnt_active), .gnt_id(gnt_id), .frame_done(frame_done),
      .frame_err(frame_err), .drop(drop)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", n, got, exp);
      end
   endtask

   // monitor: pops the expected beat of whichever source the data tag names
   always @(negedge clk) begin
      if (rst) begin
         cnt_l = '{0, 0};
         exp_done = 0;
      end else begin
         checks++;
         if (frame_done !== exp_done) begin
            errors++;
            $display("FAIL frame_done: got %b expected %b", frame_done, exp_done);
         end
         exp_done = 0;
         if (frame_done) done_cnt++;
         if (frame_err) err_cnt++;
         drop_cnt[0] += int'(drop[0]);
         drop_cnt[1] += int'(drop[1]);
         if (gnt_active) begin
            checks++;
            if (c_ready[!gnt_id] !== 1'b0) begin
               errors++;
               $display("FAIL nonowner_ready: got %b expected 0 (owner %0d)", c_ready[!gnt_id], gnt_id);
            end
         end
         if (down_valid && down_ready) begin
            automatic int src = int'(down_data[7]);
            automatic beat_t b;
            checks++;
            if (expq[src].size() == 0) begin
               errors++;
               $display("FAIL sb_ch%0d: got unexpected beat %h expected none", src, down_data);
            end else begin
               b = expq[src].pop_front();
               if ({down_data, down_tlast, down_tuser} !== b || gnt_id !== src[0]) begin
                  errors++;
                  $display("FAIL sb_ch%0d: got %h/%b/%b gnt %0d expected %h/%b/%b gnt %0d",
                           src, down_data, down_tlast, down_tuser, gnt_id, b.d, b.l, b.u, src);
               end
            end
            if (down_tuser) begin
               cnt_l[src] = 0;
               order.push_back(src);
            end
            if (down_tlast) begin
               cnt_l[src]++;
               if (cnt_l[src] == LINES) begin
                  exp_done = 1;
                  cnt_l[src] = 0;
               end
            end
         end
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      down_ready = rr ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic send(input int ch, input bit l, input bit u, input bit exp);
      beat_t b;
      int t = 0;
      b.d = {ch[0], seq[ch]};
      b.l = l;
      b.u = u;
      seq[ch] = seq[ch] + 7'd1;
      c_data[ch] = b.d;
      c_last[ch] = l;
      c_user[ch] = u;
      c_valid[ch] = 1'b1;
      if (exp) expq[ch].push_back(b);
      do begin
         @(negedge clk);
         t++;
      end while (!c_ready[ch] && t < 3000);
      if (!c_ready[ch]) chk($sformatf("timeout_ch%0d", ch), 0, 1);
      @(posedge clk);
      #1;
      c_valid[ch] = 1'b0;
   endtask

   task automatic send_frame(input int ch, input int npx, input bit gaps);
      for (int ln = 0; ln < LINES; ln++)
         for (int p = 0; p < npx; p++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin
               @(posedge clk);
               #1;
            end
            send(ch, p == npx - 1, ln == 0 && p == 0, 1);
         end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1;
      idle(2);
      rst = 0;
   endtask

   initial begin
      int d0, e0, dr0, dr1;
      c_valid = '0;
      c_last = '0;
      c_user = '0;
      c_data = '0;
      seq = '{7'd0, 7'd0};
      drop_cnt = '{0, 0};
      down_ready = 1;
      idle(3);
      rst = 0;
      @(negedge clk);
      chk("rst_gnt_active", gnt_active, 0);
      chk("rst_gnt_id", gnt_id, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_frame_err", frame_err, 0);
      chk("rst_down_valid", down_valid, 0);
      chk("rst_drop", drop, 0);
      chk("rst_ready", c_ready, 0);
      @(posedge clk);
      #1;
      send_frame(0, 8, 0);
      idle(3);
      chk("t1_done", done_cnt, 1);
      chk("t1_order", order.size() == 1 && order[0] == 0, 1);
      chk("t1_q0_empty", expq[0].size(), 0);

      do_reset();
      order.delete();
      d0 = done_cnt;
      fork
         begin
            send_frame(0, 3, 0);
            send_frame(0, 3, 0);
         end
         send_frame(1, 3, 0);
      join
      idle(3);
      chk("t2_done", done_cnt - d0, 3);
      chk("t2_order_n", order.size(), 3);
      chk("t2_order", order.size() == 3 && order[0] == 0 && order[1] == 1 && order[2] == 0, 1);

      dr0 = drop_cnt[0];
      dr1 = drop_cnt[1];
      d0 = order.size();
      repeat (3) send(1, 0, 0, 0);
      send_frame(1, 4, 0);
      idle(3);
      chk("t3_drop1", drop_cnt[1] - dr1, 3);
      chk("t3_drop0", drop_cnt[0] - dr0, 0);
      chk("t3_order", order.size() == d0 + 1 && order[d0] == 1, 1);
      chk("t3_q1_empty", expq[1].size(), 0);

      e0 = err_cnt;
      d0 = done_cnt;
      for (int p = 0; p < 4; p++) send(0, p == 3, p == 0, 1);
      for (int p = 0; p < 2; p++) send(0, 0, 0, 1);
      send_frame(0, 4, 0);
      idle(3);
      chk("t4_err", err_cnt - e0, 1);
      chk("t4_done", done_cnt - d0, 1);
      chk("t4_q0_empty", expq[0].size(), 0);
      chk("t4_order", order[order.size() - 1] == 0 && order[order.size() - 2] == 0, 1);

      for (int p = 0; p < 4; p++) send(0, p == 3, p == 0, 1);
      for (int p = 0; p < 4; p++) send(0, p == 3, 0, 1);
      for (int p = 0; p < 2; p++) send(0, 0, 0, 1);
      c_data[0] = 8'h7f;
      c_last[0] = 0;
      c_user[0] = 0;
      c_valid[0] = 1;
      rst = 1;
      @(negedge clk);
      @(negedge clk);
      chk("t6_down_valid", down_valid, 0);
      chk("t6_gnt_active", gnt_active, 0);
      @(posedge clk);
      #1;
      c_valid[0] = 0;
      rst = 0;
      d0 = done_cnt;
      send_frame(1, 3, 0);
      idle(3);
      chk("t6_done", done_cnt - d0, 1);
      chk("t6_order", order[order.size() - 1], 1);
      chk("t6_q0_empty", expq[0].size(), 0);

      rr = 1;
      d0 = done_cnt;
      e0 = err_cnt;
      dr0 = drop_cnt[0] + drop_cnt[1];
      fork
         repeat (3) send_frame(0, $urandom_range(1, 4), 1);
         repeat (3) send_frame(1, $urandom_range(1, 4), 1);
      join
      rr = 0;
      idle(5);
      chk("t5_done", done_cnt - d0, 6);
      chk("t5_err", err_cnt - e0, 0);
      chk("t5_drop", drop_cnt[0] + drop_cnt[1] - dr0, 0);
      chk("t5_q0_empty", expq[0].size(), 0);
      chk("t5_q1_empty", expq[1].size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog: got no completion expected finish before 50000 cycles");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end
endmodule
